// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command op encodings, arbiter FSM states,
// default timing constants and the round-robin pick helper.
package sdram_pkg;

    // Default timing at 100 MHz: 7.8 us refresh interval, worst-case burst length.
    localparam int unsigned SDRAM_REF_PERIOD   = 780;
    localparam int unsigned SDRAM_BURST_CYCLES = 17;

    typedef logic [1:0] cmd_op_t;

    localparam cmd_op_t OP_IDLE    = 2'b00;
    localparam cmd_op_t OP_READ    = 2'b01;
    localparam cmd_op_t OP_WRITE   = 2'b10;
    localparam cmd_op_t OP_REFRESH = 2'b11;

    localparam logic [1:0] ST_WAIT_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ISSUE     = 2'd2;
    localparam logic [1:0] ST_BUSY      = 2'd3;

    // Winning client index. With both requesting, the client not served last wins.
    function automatic logic pick_client(input logic [1:0] req, input logic rr_last);
        logic win;
        if (req == 2'b11) begin
            win = ~rr_last;
        end else begin
            win = req[1];
        end
        return win;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval timer: free-running counter once init is done, a pending
// flag raised on every wrap, a sticky overrun flag, and a burst headroom check.
module sdram_refresh_timer #(
    parameter int unsigned REF_PERIOD    = sdram_pkg::SDRAM_REF_PERIOD,
    parameter int unsigned BURST_CYCLES  = sdram_pkg::SDRAM_BURST_CYCLES,
    parameter int unsigned REF_CNT_WIDTH = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_ref_ack,
    output logic o_ref_pending,
    output logic o_ref_overrun,
    output logic o_headroom_ok
);

    localparam logic [REF_CNT_WIDTH-1:0] CntMax    = REF_CNT_WIDTH'(REF_PERIOD - 1);
    localparam logic [REF_CNT_WIDTH-1:0] CntOne    = REF_CNT_WIDTH'(1);
    localparam logic [REF_CNT_WIDTH:0]   BurstExt  = (REF_CNT_WIDTH + 1)'(BURST_CYCLES);
    localparam logic [REF_CNT_WIDTH:0]   PeriodExt = (REF_CNT_WIDTH + 1)'(REF_PERIOD);

    logic [REF_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     pending_q, pending_d;
    logic                     overrun_q, overrun_d;
    logic                     wrap;

    assign wrap = i_en && (cnt_q == CntMax);

    // Next-state: count, raise pending on wrap (wins over ack), latch overrun.
    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (i_en) begin
            cnt_d = wrap ? '0 : cnt_q + CntOne;
        end
        if (i_ref_ack) begin
            pending_d = 1'b0;
        end
        if (wrap) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // One extra bit so the sum cannot wrap before the compare.
    assign o_headroom_ok = ({1'b0, cnt_q} + BurstExt) < PeriodExt;
    assign o_ref_pending = pending_q;
    assign o_ref_overrun = overrun_q;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Arbitrates the SDRAM burst engine between two burst clients and auto-refresh.
// Refresh always wins; clients alternate; a burst that could delay a due refresh
// is held off until the refresh has been issued.
module sdram_burst_arbiter #(
    parameter int unsigned ADDR_WIDTH    = 22,
    parameter int unsigned REF_PERIOD    = sdram_pkg::SDRAM_REF_PERIOD,
    parameter int unsigned BURST_CYCLES  = sdram_pkg::SDRAM_BURST_CYCLES,
    parameter int unsigned REF_CNT_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_init_done,
    input  logic [1:0]              i_req,
    input  logic [1:0]              i_rw,
    input  logic [2*ADDR_WIDTH-1:0] i_addr,
    output logic [1:0]              o_gnt,
    output logic                    o_cmd_valid,
    output logic [1:0]              o_cmd_op,
    output logic [ADDR_WIDTH-1:0]   o_cmd_addr,
    output logic                    o_cmd_src,
    input  logic                    i_cmd_ready,
    input  logic                    i_cmd_done,
    output logic                    o_busy,
    output logic                    o_ref_overrun
);

    import sdram_pkg::*;

    logic [1:0]            state_q, state_d;
    cmd_op_t               op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  src_q, src_d;
    logic                  rr_last_q, rr_last_d;
    logic                  winner;
    logic                  accept;
    logic                  ref_ack;
    logic                  ref_pending;
    logic                  headroom_ok;

    assign accept  = (state_q == ST_ISSUE) && i_cmd_ready;
    assign ref_ack = accept && (op_q == OP_REFRESH);

    sdram_refresh_timer #(
        .REF_PERIOD    (REF_PERIOD),
        .BURST_CYCLES  (BURST_CYCLES),
        .REF_CNT_WIDTH (REF_CNT_WIDTH)
    ) u_timer (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_init_done),
        .i_ref_ack     (ref_ack),
        .o_ref_pending (ref_pending),
        .o_ref_overrun (o_ref_overrun),
        .o_headroom_ok (headroom_ok)
    );

    // Next-state: decide in IDLE, hold the command in ISSUE, wait for done in BUSY.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        src_d     = src_q;
        rr_last_d = rr_last_q;
        winner    = pick_client(i_req, rr_last_q);
        case (state_q)
            ST_WAIT_INIT: begin
                if (i_init_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (ref_pending) begin
                    op_d    = OP_REFRESH;
                    addr_d  = '0;
                    state_d = ST_ISSUE;
                end else if ((|i_req) && headroom_ok) begin
                    op_d    = i_rw[winner] ? OP_WRITE : OP_READ;
                    addr_d  = winner ? i_addr[2*ADDR_WIDTH-1 -: ADDR_WIDTH]
                                     : i_addr[ADDR_WIDTH-1:0];
                    src_d   = winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_cmd_ready) begin
                    // Refresh leaves the round-robin pointer untouched.
                    if (op_q != OP_REFRESH) begin
                        rr_last_d = src_q;
                    end
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_cmd_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_INIT;
        endcase
    end

    // Arbiter state registers; rr_last resets to 1 so client 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_WAIT_INIT;
            op_q      <= OP_IDLE;
            addr_q    <= '0;
            src_q     <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Command outputs are only non-idle while the command is being offered.
    always_comb begin
        o_cmd_valid = (state_q == ST_ISSUE);
        o_cmd_op    = o_cmd_valid ? op_q : OP_IDLE;
        o_cmd_addr  = o_cmd_valid ? addr_q : '0;
        o_cmd_src   = src_q;
        o_busy      = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
        o_gnt       = 2'b00;
        if (accept && (op_q != OP_REFRESH)) begin
            o_gnt = src_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Directed bench for sdram_burst_arbiter with a short refresh period (64 clocks).
module tb_sdram_burst_arbiter;

    localparam int unsigned AW       = 22;
    localparam int unsigned RP       = 64;
    localparam int unsigned BC       = 17;
    localparam int unsigned CW       = 10;
    localparam int          DONE_LAT = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [1:0]    rw = 2'b00;
    logic [2*AW-1:0] addr = '0;
    logic          cmd_ready = 1'b1;
    logic          cmd_done = 1'b0;
    logic [1:0]    o_gnt;
    logic          o_cmd_valid;
    logic [1:0]    o_cmd_op;
    logic [AW-1:0] o_cmd_addr;
    logic          o_cmd_src;
    logic          o_busy;
    logic          o_ref_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt;

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    rw;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    exp_gnt;
        logic [1:0]    exp_op;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[8];

    sdram_burst_arbiter #(
        .ADDR_WIDTH    (AW),
        .REF_PERIOD    (RP),
        .BURST_CYCLES  (BC),
        .REF_CNT_WIDTH (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_init_done   (init_done),
        .i_req         (req),
        .i_rw          (rw),
        .i_addr        (addr),
        .o_gnt         (o_gnt),
        .o_cmd_valid   (o_cmd_valid),
        .o_cmd_op      (o_cmd_op),
        .o_cmd_addr    (o_cmd_addr),
        .o_cmd_src     (o_cmd_src),
        .i_cmd_ready   (cmd_ready),
        .i_cmd_done    (cmd_done),
        .o_busy        (o_busy),
        .o_ref_overrun (o_ref_overrun)
    );

    always #5 clk = ~clk;

    // Reference refresh counter: counts clocks with init_done high, period RP.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else if (init_done) m_cnt <= (m_cnt == RP - 1) ? 0 : m_cnt + 1;
    end

    // Engine model: pulses done DONE_LAT clocks after each accepted command.
    initial begin : engine
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt      = 0;
                cmd_done = 1'b0;
            end else begin
                cmd_done = 1'b0;
                if (cnt != 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) cmd_done = 1'b1;
                end
                if (o_cmd_valid && cmd_ready) cnt = DONE_LAT;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     32'(o_gnt), 32'd0);
        check({tag, "_valid"},   32'(o_cmd_valid), 32'd0);
        check({tag, "_op"},      32'(o_cmd_op), 32'd0);
        check({tag, "_addr"},    32'(o_cmd_addr), 32'd0);
        check({tag, "_src"},     32'(o_cmd_src), 32'd0);
        check({tag, "_busy"},    32'(o_busy), 32'd0);
        check({tag, "_overrun"}, 32'(o_ref_overrun), 32'd0);
    endtask

    // Tick until a client command is offered; refreshes on the way are checked and let through.
    task automatic wait_burst(input int budget, output logic found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (o_cmd_valid && cmd_ready) begin
                if (o_cmd_op == 2'b11) begin
                    check("refresh_no_gnt", 32'(o_gnt), 32'd0);
                    check("refresh_addr", 32'(o_cmd_addr), 32'd0);
                end else begin
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_cnt(input int target, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (m_cnt == target && !o_busy) ok = 1'b1;
        end
    endtask

    initial begin : main
        logic found;
        logic bad;
        logic ref_seen;
        logic got;
        int   gnt_pulses;

        // Starts right after the init grant, so client 0 was served last.
        vecs[0] = '{2'b11, 2'b01, 22'h000001, 22'h3FFFFF, 2'b10, 2'b01, 22'h3FFFFF};
        vecs[1] = '{2'b11, 2'b10, 22'h155555, 22'h2AAAAA, 2'b01, 2'b01, 22'h155555};
        vecs[2] = '{2'b11, 2'b10, 22'h0ABCDE, 22'h123456, 2'b10, 2'b10, 22'h123456};
        vecs[3] = '{2'b11, 2'b01, 22'h3FFFFF, 22'h000000, 2'b01, 2'b10, 22'h3FFFFF};
        vecs[4] = '{2'b10, 2'b00, 22'h000000, 22'h000042, 2'b10, 2'b01, 22'h000042};
        vecs[5] = '{2'b10, 2'b11, 22'h000000, 22'h1F0F0F, 2'b10, 2'b10, 22'h1F0F0F};
        vecs[6] = '{2'b01, 2'b00, 22'h200000, 22'h000000, 2'b01, 2'b01, 22'h200000};
        vecs[7] = '{2'b11, 2'b11, 22'h00AAAA, 22'h00BBBB, 2'b10, 2'b10, 22'h00BBBB};

        // Reset values
        #12;
        check_reset_outputs("reset");

        // Init gating
        tick();
        rst_n = 1'b1;
        req   = 2'b01;
        rw    = 2'b01;
        addr  = {22'h0, 22'h15A5A5};
        bad   = 1'b0;
        repeat (50) begin
            tick();
            if (o_cmd_valid) bad = 1'b1;
        end
        check("init_no_valid", 32'(bad), 32'd0);
        check("init_ref_cnt", 32'(dut.u_timer.cnt_q), 32'd0);
        init_done = 1'b1;
        wait_burst(3, found);
        check("init_found", 32'(found), 32'd1);
        check("init_gnt", 32'(o_gnt), 32'd1);
        check("init_op", 32'(o_cmd_op), 32'd2);
        check("init_addr", 32'(o_cmd_addr), 32'h15A5A5);

        // Round-robin / single-requester vectors
        for (int k = 0; k < 8; k++) begin
            req  = vecs[k].req;
            rw   = vecs[k].rw;
            addr = {vecs[k].a1, vecs[k].a0};
            wait_burst(200, found);
            check($sformatf("vec%0d_found", k), 32'(found), 32'd1);
            check($sformatf("vec%0d_gnt", k), 32'(o_gnt), 32'(vecs[k].exp_gnt));
            check($sformatf("vec%0d_op", k), 32'(o_cmd_op), 32'(vecs[k].exp_op));
            check($sformatf("vec%0d_addr", k), 32'(o_cmd_addr), 32'(vecs[k].exp_addr));
            check($sformatf("vec%0d_src", k), 32'(o_cmd_src), 32'(vecs[k].exp_gnt[1]));
        end
        req = 2'b00;

        // Headroom boundary: decision at ref_cnt=46 still fits a burst
        wait_cnt(46, found);
        check("hr46_sync", 32'(found), 32'd1);
        req  = 2'b01;
        rw   = 2'b00;
        addr = {22'h0, 22'h0F0F0F};
        tick();
        check("hr46_valid", 32'(o_cmd_valid), 32'd1);
        check("hr46_op", 32'(o_cmd_op), 32'd1);
        check("hr46_gnt", 32'(o_gnt), 32'd1);
        req = 2'b00;

        // Refresh priority: request at ref_cnt=47 must wait for the refresh
        wait_cnt(47, found);
        check("hr47_sync", 32'(found), 32'd1);
        req      = 2'b01;
        rw       = 2'b01;
        addr     = {22'h0, 22'h3A5A5A};
        ref_seen = 1'b0;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (o_cmd_valid && o_cmd_op == 2'b11) ref_seen = 1'b1;
            if (o_gnt != 2'b00) begin
                got = 1'b1;
                check("hr47_refresh_first", 32'(ref_seen), 32'd1);
                check("hr47_gnt", 32'(o_gnt), 32'd1);
                check("hr47_op", 32'(o_cmd_op), 32'd2);
                check("hr47_addr", 32'(o_cmd_addr), 32'h3A5A5A);
            end
        end
        check("hr47_granted", 32'(got), 32'd1);
        req = 2'b00;
        tick();

        // Backpressure: command held stable, grant only on the accept cycle
        cmd_ready  = 1'b0;
        req        = 2'b01;
        rw         = 2'b01;
        addr       = {22'h0, 22'h2D2D2D};
        gnt_pulses = 0;
        found      = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (o_cmd_valid) found = 1'b1;
        end
        check("bp_found", 32'(found), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(o_cmd_valid), 32'd1);
            check("bp_op", 32'(o_cmd_op), 32'd2);
            check("bp_addr", 32'(o_cmd_addr), 32'h2D2D2D);
            if (o_gnt != 2'b00) gnt_pulses++;
            tick();
        end
        cmd_ready = 1'b1;
        #1;
        check("bp_accept_gnt", 32'(o_gnt), 32'd1);
        if (o_gnt != 2'b00) gnt_pulses++;
        req = 2'b00;
        tick();
        if (o_gnt != 2'b00) gnt_pulses++;
        check("bp_valid_drop", 32'(o_cmd_valid), 32'd0);
        check("bp_busy", 32'(o_busy), 32'd1);
        check("bp_gnt_pulses", 32'(gnt_pulses), 32'd1);

        // Overrun: refresh stalled beyond a full period
        check("ovr_before", 32'(o_ref_overrun), 32'd0);
        cmd_ready = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (o_cmd_valid && o_cmd_op == 2'b11) found = 1'b1;
        end
        check("ovr_refresh_found", 32'(found), 32'd1);
        repeat (70) tick();
        check("ovr_set", 32'(o_ref_overrun), 32'd1);
        check("ovr_still_valid", 32'(o_cmd_valid), 32'd1);
        check("ovr_op", 32'(o_cmd_op), 32'd3);
        cmd_ready = 1'b1;
        #1;
        check("ovr_refresh_no_gnt", 32'(o_gnt), 32'd0);
        tick();
        check("ovr_sticky", 32'(o_ref_overrun), 32'd1);
        check("ovr_busy", 32'(o_busy), 32'd1);

        // Asynchronous reset while BUSY
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        req  = 2'b11;
        rw   = 2'b00;
        addr = {22'h111111, 22'h222222};
        tick();
        tick();
        rst_n = 1'b1;
        wait_burst(10, found);
        check("post_rst_found", 32'(found), 32'd1);
        check("post_rst_gnt", 32'(o_gnt), 32'd1);
        check("post_rst_op", 32'(o_cmd_op), 32'd1);
        check("post_rst_addr", 32'(o_cmd_addr), 32'h222222);
        req = 2'b00;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
